fluxo_jogo_n: RTL and testbench
===============================

FLUXO_JOGO_N -- requirements
Module: fluxo_jogo_n

Interface
- REQ-001 SHALL have parameter N_BOTOES, default 4: buttons, LEDs and expected-pattern width.
- REQ-002 SHALL have parameter DEPTH, default 16: sequence length; AW = $clog2(DEPTH).
- REQ-003 SHALL have parameter N_MODOS, default 4: selectable modes; MW = $clog2(N_MODOS).
- REQ-004 SHALL have parameter TIMEOUT_TICKS, default 300: timer length in ticks.
- REQ-005 SHALL have parameter DIV, default 1000: clock cycles per timer tick.
- REQ-006 SHALL have parameters PISCADAS, default 3, and LED_CYC, default 500: LED blink count and half-period.
- REQ-007 SHALL have parameter MAX_ACERTOS, default 3: hit-counter saturation value.
- REQ-008 SHALL have these ports:
  - clock in 1: single clock.
  - reset in 1: asynchronous, active-low.
  - zeraS/contaS in 1/1: sequence clear/advance.
  - limite in AW: last address of the round.
  - zeraR/registraR in 1/1: play register clear/load.
  - zeraT/contaT in 1/1: timer clear/run.
  - zeraA/contaA in 1/1: hits and blink clear/hit increment.
  - contaPiscadas in 1: start blinking.
  - contaM/mais/menos in 1/1/1: mode enable/up/down levels.
  - botoes in N_BOTOES: raw buttons.
  - esperado in N_BOTOES: expected pattern from external ROM.
  - leds_mem in N_BOTOES: LED pattern from external ROM.
  - endereco out AW: ROM address.
  - modo out MW: ROM bank select.
  - tem_jogada out 1: press pulse.
  - acertouJogada out 1: play matches the expected pattern.
  - fimS out 1: last address reached.
  - timeout out 1: sticky timeout flag.
  - tempo_restante out $clog2(TIMEOUT_TICKS+1): ticks remaining.
  - tempo_bcd out 12: BCD of tempo_restante.
  - acertos out $clog2(MAX_ACERTOS+1): hit count.
  - leds out N_BOTOES: LED drive.
  - fimPiscaLeds out 1: blinking done.
  - db_jogada out N_BOTOES: registered play, for debug.

Function
- REQ-009 SHALL increment endereco on contaS; zeraS has priority and sets it to 0; fimS = (endereco == limite); contaS at endereco == limite wraps to 0.
- REQ-010 SHALL rising-edge-detect mais and menos; when contaM is high, modo +1/-1 per edge, wrapping N_MODOS-1 <-> 0; simultaneous edges cause no change.
- REQ-011 SHALL register tem_jogada as a 1-cycle pulse, one cycle after |botoes rises.
- REQ-012 SHALL load the play register from botoes on registraR; zeraR has priority.
- REQ-013 SHALL drive acertouJogada combinationally = (db_jogada == esperado) && (db_jogada != 0).
- REQ-014 SHALL run the timer only while contaT is high:
  - A prescaler counts DIV cycles per tick.
  - tempo_restante decrements from TIMEOUT_TICKS once per tick.
  - On reaching 0 it holds and sets timeout, which stays set until zeraT.
  - zeraT reloads TIMEOUT_TICKS and clears the prescaler in the same cycle.
- REQ-015 SHALL increment acertos on contaA, saturating at MAX_ACERTOS; zeraA sets it to 0.
- REQ-016 SHALL run the blink FSM with states IDLE, ON, OFF, DONE:
  - IDLE->ON on the contaPiscadas rising edge.
  - ON->OFF after LED_CYC cycles.
  - OFF->ON after LED_CYC cycles, or OFF->DONE after the PISCADAS-th OFF.
  - DONE->IDLE on zeraA.
  - zeraA from any state returns the FSM to IDLE.
- REQ-017 SHALL drive leds = leds_mem in IDLE, leds_mem in ON, 0 in OFF, 0 in DONE; fimPiscaLeds = 1 only in DONE.
- REQ-018 SHALL give all synchronous clears priority over their enables in the same cycle.

Reset
- REQ-019 SHALL, on reset low, asynchronously set:
  - endereco = 0, modo = 0, play register = 0, acertos = 0.
  - tempo_restante = TIMEOUT_TICKS, prescaler = 0, timeout = 0.
  - blink FSM = IDLE, edge detectors = 0, tem_jogada = 0.
- REQ-020 SHALL, on reset mid-blink or mid-count, abort to the reset values; no pulse is emitted on release.

Configuration
- REQ-021 SHALL, with FLUXO_JOGO_N_BCD_EN defined, drive tempo_bcd as the registered BCD of tempo_restante, one cycle behind; without it, tempo_bcd = 0 and no BCD logic is synthesised.

Structure
- REQ-022 SHALL place the blink-state enum (IDLE, ON, OFF, DONE) and the default parameter constants in package fluxo_jogo_pkg.
- REQ-023 SHALL implement the blink FSM as sub-module pisca_leds_fsm; all other logic stays inline.

Verification
- REQ-024 SHALL cover: limite=3, contaS for 5 cycles -> endereco 1,2,3,0,1; fimS high only while endereco=3.
- REQ-025 SHALL cover: DIV=2, TIMEOUT_TICKS=5, contaT held high -> tempo_restante reaches 0 after 10 cycles, timeout=1; zeraT -> tempo_restante=5, timeout=0.
- REQ-026 SHALL cover: botoes=0100, registraR, esperado=0100 -> acertouJogada=1; esperado=0010 -> 0; tem_jogada is a single pulse.
- REQ-027 SHALL cover: mais edges x5 with N_MODOS=4 and contaM=1 -> modo 1,2,3,0,1; mais and menos rising together -> modo unchanged.
- REQ-028 SHALL cover: LED_CYC=2, PISCADAS=3, contaPiscadas pulse -> leds pattern ON/OFF three times, then DONE with fimPiscaLeds=1; reset during ON -> IDLE, leds=leds_mem.
- REQ-029 SHALL cover: contaA x5 with MAX_ACERTOS=3 -> acertos saturates at 3; with FLUXO_JOGO_N_BCD_EN, tempo_restante=300 -> tempo_bcd=0x300 one cycle later.

Source files
------------

// File: rtl/fluxo_jogo_pkg.sv
// Shared types and default constants for the fluxo_jogo_n game datapath.
// Holds the blink-state enum and a binary-to-BCD helper.
package fluxo_jogo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2,
      DONE = 2'd3
   } pisca_t;

   localparam int unsigned N_BOTOES_DEF      = 4;
   localparam int unsigned DEPTH_DEF         = 16;
   localparam int unsigned N_MODOS_DEF       = 4;
   localparam int unsigned TIMEOUT_TICKS_DEF = 300;
   localparam int unsigned DIV_DEF           = 1000;
   localparam int unsigned PISCADAS_DEF      = 3;
   localparam int unsigned LED_CYC_DEF       = 500;
   localparam int unsigned MAX_ACERTOS_DEF   = 3;

   // Shift-and-add-3 conversion; values above 999 lose the thousands.
   function automatic logic [11:0] bin_to_bcd(input logic [15:0] v);
      logic [27:0] r;
      r = {12'd0, v};
      for (int i = 0; i < 16; i++) begin
         if (r[19:16] > 4'd4) r[19:16] = r[19:16] + 4'd3;
         if (r[23:20] > 4'd4) r[23:20] = r[23:20] + 4'd3;
         if (r[27:24] > 4'd4) r[27:24] = r[27:24] + 4'd3;
         r = r << 1;
      end
      return r[27:16];
   endfunction

endpackage

// File: rtl/fluxo_jogo_n_pisca.sv
// LED blink sequencer: shows the ROM pattern, blinks it a fixed number
// of times on request, then parks in DONE until the hit counter is cleared.
module pisca_leds_fsm
   import fluxo_jogo_pkg::*;
#(
   parameter int unsigned N_BOTOES = N_BOTOES_DEF,
   parameter int unsigned PISCADAS = PISCADAS_DEF,
   parameter int unsigned LED_CYC  = LED_CYC_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                zeraA,
   input  logic                contaPiscadas,
   input  logic [N_BOTOES-1:0] leds_mem,
   output logic [N_BOTOES-1:0] leds,
   output logic                fimPiscaLeds
);

   localparam int CYW = (LED_CYC > 1) ? $clog2(LED_CYC) : 1;
   localparam int PCW = (PISCADAS > 1) ? $clog2(PISCADAS) : 1;

   pisca_t           r_estado;
   pisca_t           w_prox;
   logic             r_cp_d;
   logic [CYW-1:0]   r_cyc;
   logic [PCW-1:0]   r_pisc;
   logic             w_cp_up;
   logic             w_fim_fase;
   logic             w_ult;

   assign w_cp_up    = contaPiscadas & ~r_cp_d;
   assign w_fim_fase = (r_cyc == CYW'(LED_CYC - 1));
   assign w_ult      = (r_pisc == PCW'(PISCADAS - 1));

   // State register and start-request edge detector.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado <= IDLE;
         r_cp_d   <= 1'b0;
      end else begin
         r_estado <= w_prox;
         r_cp_d   <= contaPiscadas;
      end
   end

   // Phase-length counter and count of completed OFF phases.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cyc  <= '0;
         r_pisc <= '0;
      end else if (zeraA || r_estado == IDLE || r_estado == DONE) begin
         r_cyc  <= '0;
         r_pisc <= '0;
      end else if (w_fim_fase) begin
         r_cyc <= '0;
         if (r_estado == OFF) r_pisc <= r_pisc + 1'b1;
      end else begin
         r_cyc <= r_cyc + 1'b1;
      end
   end

   // Next state and LED drive; clearing hits always returns to IDLE.
   always_comb begin
      w_prox       = r_estado;
      leds         = '0;
      fimPiscaLeds = 1'b0;
      unique case (r_estado)
         IDLE: begin
            leds = leds_mem;
            if (w_cp_up) w_prox = ON;
         end
         ON: begin
            leds = leds_mem;
            if (w_fim_fase) w_prox = OFF;
         end
         OFF: begin
            if (w_fim_fase) w_prox = w_ult ? DONE : ON;
         end
         DONE: begin
            fimPiscaLeds = 1'b1;
         end
         default: w_prox = IDLE;
      endcase
      if (zeraA) w_prox = IDLE;
   end

endmodule

// File: rtl/fluxo_jogo_n.sv
// Datapath for the memory game: sequence address, mode, play register,
// countdown timer, hit counter and LED blinker. FLUXO_JOGO_N_BCD_EN adds BCD time.
module fluxo_jogo_n
   import fluxo_jogo_pkg::*;
#(
   parameter int unsigned N_BOTOES      = N_BOTOES_DEF,
   parameter int unsigned DEPTH         = DEPTH_DEF,
   parameter int unsigned N_MODOS       = N_MODOS_DEF,
   parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
   parameter int unsigned DIV           = DIV_DEF,
   parameter int unsigned PISCADAS      = PISCADAS_DEF,
   parameter int unsigned LED_CYC       = LED_CYC_DEF,
   parameter int unsigned MAX_ACERTOS   = MAX_ACERTOS_DEF
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                zeraS,
   input  logic                                contaS,
   input  logic [$clog2(DEPTH)-1:0]            limite,
   input  logic                                zeraR,
   input  logic                                registraR,
   input  logic                                zeraT,
   input  logic                                contaT,
   input  logic                                zeraA,
   input  logic                                contaA,
   input  logic                                contaPiscadas,
   input  logic                                contaM,
   input  logic                                mais,
   input  logic                                menos,
   input  logic [N_BOTOES-1:0]                 botoes,
   input  logic [N_BOTOES-1:0]                 esperado,
   input  logic [N_BOTOES-1:0]                 leds_mem,
   output logic [$clog2(DEPTH)-1:0]            endereco,
   output logic [$clog2(N_MODOS)-1:0]          modo,
   output logic                                tem_jogada,
   output logic                                acertouJogada,
   output logic                                fimS,
   output logic                                timeout,
   output logic [$clog2(TIMEOUT_TICKS+1)-1:0]  tempo_restante,
   output logic [11:0]                         tempo_bcd,
   output logic [$clog2(MAX_ACERTOS+1)-1:0]    acertos,
   output logic [N_BOTOES-1:0]                 leds,
   output logic                                fimPiscaLeds,
   output logic [N_BOTOES-1:0]                 db_jogada
);

   localparam int AW = $clog2(DEPTH);
   localparam int MW = $clog2(N_MODOS);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam int CW = $clog2(MAX_ACERTOS + 1);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [AW-1:0]       r_end;
   logic [MW-1:0]       r_modo;
   logic                r_mais_d;
   logic                r_menos_d;
   logic                r_any_d;
   logic                r_tem;
   logic [N_BOTOES-1:0] r_jogada;
   logic [PW-1:0]       r_presc;
   logic [TW-1:0]       r_tempo;
   logic                r_timeout;
   logic [CW-1:0]       r_acertos;
   logic                w_mais_up;
   logic                w_menos_up;
   logic                w_any;
   logic                w_tick;

   assign w_mais_up  = mais & ~r_mais_d;
   assign w_menos_up = menos & ~r_menos_d;
   assign w_any      = |botoes;
   assign w_tick     = (r_presc == PW'(DIV - 1));

   // Sequence address: clear wins, advance wraps after the round limit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_end <= '0;
      end else if (zeraS) begin
         r_end <= '0;
      end else if (contaS) begin
         if (r_end == limite) r_end <= '0;
         else                 r_end <= r_end + 1'b1;
      end
   end

   // Mode select stepped by button edges; opposing edges cancel.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_modo    <= '0;
         r_mais_d  <= 1'b0;
         r_menos_d <= 1'b0;
      end else begin
         r_mais_d  <= mais;
         r_menos_d <= menos;
         if (contaM && w_mais_up && !w_menos_up) begin
            if (r_modo == MW'(N_MODOS - 1)) r_modo <= '0;
            else                            r_modo <= r_modo + 1'b1;
         end else if (contaM && w_menos_up && !w_mais_up) begin
            if (r_modo == '0) r_modo <= MW'(N_MODOS - 1);
            else              r_modo <= r_modo - 1'b1;
         end
      end
   end

   // Press pulse on the first cycle any button is seen.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_any_d <= 1'b0;
         r_tem   <= 1'b0;
      end else begin
         r_any_d <= w_any;
         r_tem   <= w_any & ~r_any_d;
      end
   end

   // Play register captured from the raw buttons.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)         r_jogada <= '0;
      else if (zeraR)     r_jogada <= '0;
      else if (registraR) r_jogada <= botoes;
   end

   // Countdown timer; holds at zero with a sticky timeout flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_presc   <= '0;
         r_tempo   <= TW'(TIMEOUT_TICKS);
         r_timeout <= 1'b0;
      end else if (zeraT) begin
         r_presc   <= '0;
         r_tempo   <= TW'(TIMEOUT_TICKS);
         r_timeout <= 1'b0;
      end else if (contaT) begin
         if (w_tick) begin
            r_presc <= '0;
            if (r_tempo > TW'(1)) begin
               r_tempo <= r_tempo - 1'b1;
            end else begin
               r_tempo   <= '0;
               r_timeout <= 1'b1;
            end
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   // Hit counter saturating at its maximum.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_acertos <= '0;
      end else if (zeraA) begin
         r_acertos <= '0;
      end else if (contaA && r_acertos != CW'(MAX_ACERTOS)) begin
         r_acertos <= r_acertos + 1'b1;
      end
   end

`ifdef FLUXO_JOGO_N_BCD_EN
   logic [11:0] r_bcd;

   // Registered decimal view of the remaining time.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_bcd <= bin_to_bcd(16'(TIMEOUT_TICKS));
      else        r_bcd <= bin_to_bcd(16'(r_tempo));
   end

   assign tempo_bcd = r_bcd;
`else
   assign tempo_bcd = 12'd0;
`endif

   pisca_leds_fsm #(
      .N_BOTOES (N_BOTOES),
      .PISCADAS (PISCADAS),
      .LED_CYC  (LED_CYC)
   ) u_pisca (
      .clock         (clock),
      .reset         (reset),
      .zeraA         (zeraA),
      .contaPiscadas (contaPiscadas),
      .leds_mem      (leds_mem),
      .leds          (leds),
      .fimPiscaLeds  (fimPiscaLeds)
   );

   assign endereco       = r_end;
   assign fimS           = (r_end == limite);
   assign modo           = r_modo;
   assign tem_jogada     = r_tem;
   assign db_jogada      = r_jogada;
   assign acertouJogada  = (r_jogada == esperado) && (r_jogada != '0);
   assign tempo_restante = r_tempo;
   assign timeout        = r_timeout;
   assign acertos        = r_acertos;

endmodule

// File: tb/tb_fluxo_jogo_n.sv
// Bench for fluxo_jogo_n: directed steps plus randomized phases checked
// against arithmetic models of address, mode, play, timer, hits and blink.
module tb_fluxo_jogo_n;

   localparam int NB = 4;
   localparam int TT = 5;
   localparam int DV = 2;
   localparam int PS = 3;
   localparam int LC = 2;
   localparam int MA = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          zeraS, contaS, zeraR, registraR, zeraT, contaT;
   logic          zeraA, contaA, contaPiscadas, contaM, mais, menos;
   logic [3:0]    limite;
   logic [NB-1:0] botoes, esperado, leds_mem;
   logic [3:0]    endereco;
   logic [1:0]    modo;
   logic          tem_jogada, acertouJogada, fimS, timeout, fimPiscaLeds;
   logic [2:0]    tempo_restante;
   logic [11:0]   tempo_bcd;
   logic [1:0]    acertos;
   logic [NB-1:0] leds, db_jogada;

   logic [3:0]    e2;
   logic [1:0]    m2;
   logic          t2a, t2b, t2c, t2d, t2e;
   logic [8:0]    tr2;
   logic [11:0]   bcd2;
   logic [1:0]    ac2;
   logic [NB-1:0] l2, j2;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   fluxo_jogo_n #(
      .N_BOTOES(NB), .DEPTH(16), .N_MODOS(4), .TIMEOUT_TICKS(TT),
      .DIV(DV), .PISCADAS(PS), .LED_CYC(LC), .MAX_ACERTOS(MA)
   ) dut (
      .clock(clock), .reset(reset), .zeraS(zeraS), .contaS(contaS),
      .limite(limite), .zeraR(zeraR), .registraR(registraR),
      .zeraT(zeraT), .contaT(contaT), .zeraA(zeraA), .contaA(contaA),
      .contaPiscadas(contaPiscadas), .contaM(contaM), .mais(mais),
      .menos(menos), .botoes(botoes), .esperado(esperado),
      .leds_mem(leds_mem), .endereco(endereco), .modo(modo),
      .tem_jogada(tem_jogada), .acertouJogada(acertouJogada),
      .fimS(fimS), .timeout(timeout), .tempo_restante(tempo_restante),
      .tempo_bcd(tempo_bcd), .acertos(acertos), .leds(leds),
      .fimPiscaLeds(fimPiscaLeds), .db_jogada(db_jogada)
   );

   fluxo_jogo_n #(
      .N_BOTOES(NB), .TIMEOUT_TICKS(300)
   ) dut2 (
      .clock(clock), .reset(reset), .zeraS(1'b0), .contaS(1'b0),
      .limite(4'd0), .zeraR(1'b0), .registraR(1'b0),
      .zeraT(1'b0), .contaT(1'b0), .zeraA(1'b0), .contaA(1'b0),
      .contaPiscadas(1'b0), .contaM(1'b0), .mais(1'b0),
      .menos(1'b0), .botoes(4'd0), .esperado(4'd0),
      .leds_mem(4'd0), .endereco(e2), .modo(m2),
      .tem_jogada(t2a), .acertouJogada(t2b),
      .fimS(t2c), .timeout(t2d), .tempo_restante(tr2),
      .tempo_bcd(bcd2), .acertos(ac2), .leds(l2),
      .fimPiscaLeds(t2e), .db_jogada(j2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int bcd(input int v);
      return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
   endfunction

   function automatic int exp_bcd(input int v);
`ifdef FLUXO_JOGO_N_BCD_EN
      return bcd(v);
`else
      return (v < 0) ? 1 : 0;
`endif
   endfunction

   initial begin
      int e, lim, m, pm, pn, a, b, cm, j, pa, es, t, act, pt, h;
      logic zs, cs, rr, zr, bt, up, dn;
      logic [NB-1:0] bv;

      zeraS = 0; contaS = 0; zeraR = 0; registraR = 0; zeraT = 0;
      contaT = 0; zeraA = 0; contaA = 0; contaPiscadas = 0;
      contaM = 0; mais = 0; menos = 0; limite = 0;
      botoes = 0; esperado = 0; leds_mem = 4'b1010;

      repeat (2) tick();
      reset = 1;
      tick();

      chk("rst_end", endereco, 0);
      chk("rst_modo", modo, 0);
      chk("rst_jog", db_jogada, 0);
      chk("rst_acertos", acertos, 0);
      chk("rst_tempo", tempo_restante, TT);
      chk("rst_timeout", timeout, 0);
      chk("rst_tem", tem_jogada, 0);
      chk("rst_leds", leds, 4'b1010);
      chk("rst_fim", fimPiscaLeds, 0);
      chk("rst_bcd", tempo_bcd, exp_bcd(TT));
      chk("rst_tempo300", tr2, 300);
      chk("rst_bcd300", bcd2, exp_bcd(300));

      // sequence address, directed
      limite = 3; zeraS = 1; tick(); zeraS = 0; contaS = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("seq_end", endereco, (k + 1) % 4);
         chk("seq_fimS", fimS, ((k + 1) % 4) == 3);
      end
      contaS = 0;
      e = 1;
      // sequence address, random
      for (int k = 0; k < 40; k++) begin
         lim = $urandom_range(0, 15);
         zs = ($urandom_range(0, 7) == 0);
         cs = 1'($urandom_range(0, 1));
         limite = 4'(lim); zeraS = zs; contaS = cs;
         tick();
         if (zs) e = 0;
         else if (cs) e = (e == lim) ? 0 : (e + 1) % 16;
         chk("rseq_end", endereco, e);
         chk("rseq_fimS", fimS, e == lim);
      end
      zeraS = 0; contaS = 0;

      // mode, directed
      contaM = 1;
      for (int k = 0; k < 5; k++) begin
         mais = 1; tick();
         chk("modo_up", modo, (k + 1) % 4);
         mais = 0; tick();
      end
      mais = 1; menos = 1; tick();
      chk("modo_both", modo, 1);
      mais = 0; menos = 0; tick();
      // mode, random
      m = 1; pm = 0; pn = 0;
      for (int k = 0; k < 40; k++) begin
         a = $urandom_range(0, 1); b = $urandom_range(0, 1);
         cm = ($urandom_range(0, 3) != 0) ? 1 : 0;
         mais = 1'(a); menos = 1'(b); contaM = 1'(cm);
         tick();
         up = (a == 1) && (pm == 0);
         dn = (b == 1) && (pn == 0);
         if (cm == 1 && up != dn) m = up ? (m + 1) % 4 : (m + 3) % 4;
         pm = a; pn = b;
         chk("rmodo", modo, m);
      end
      mais = 0; menos = 0; contaM = 0; tick();

      // play register, directed
      botoes = 4'b0100; registraR = 1; tick();
      chk("jog_tem1", tem_jogada, 1);
      chk("jog_reg", db_jogada, 4'b0100);
      registraR = 0; esperado = 4'b0100; #1;
      chk("jog_hit", acertouJogada, 1);
      esperado = 4'b0010; #1;
      chk("jog_miss", acertouJogada, 0);
      tick();
      chk("jog_tem0", tem_jogada, 0);
      botoes = 0; tick();
      // play register, random
      j = 4; pa = 0;
      for (int k = 0; k < 30; k++) begin
         bv = 4'($urandom_range(0, 15));
         rr = 1'($urandom_range(0, 1));
         zr = ($urandom_range(0, 5) == 0);
         es = ($urandom_range(0, 1) == 1) ? int'(bv) : $urandom_range(0, 15);
         botoes = bv; registraR = rr; zeraR = zr; esperado = 4'(es);
         tick();
         if (zr) j = 0;
         else if (rr) j = int'(bv);
         chk("rjog_reg", db_jogada, j);
         chk("rjog_tem", tem_jogada, (bv != 0) && (pa == 0));
         chk("rjog_hit", acertouJogada, (j == es) && (j != 0));
         pa = (bv != 0) ? 1 : 0;
      end
      botoes = 0; registraR = 0; zeraR = 0; tick();

      // timer, directed
      zeraT = 1; tick(); zeraT = 0;
      chk("tmr_load", tempo_restante, TT);
      chk("tmr_to0", timeout, 0);
      pt = TT;
      contaT = 1;
      for (int c = 1; c <= 13; c++) begin
         tick();
         t = (TT - c / DV > 0) ? TT - c / DV : 0;
         chk("tmr_val", tempo_restante, t);
         chk("tmr_to", timeout, t == 0);
         chk("tmr_bcd", tempo_bcd, exp_bcd(pt));
         pt = t;
      end
      zeraT = 1; tick(); zeraT = 0;
      chk("tmr_reload", tempo_restante, TT);
      chk("tmr_clr", timeout, 0);
      // timer, random run/pause
      act = 0; pt = TT;
      for (int k = 0; k < 30; k++) begin
         bt = 1'($urandom_range(0, 1));
         contaT = bt;
         tick();
         if (bt) act++;
         t = (TT - act / DV > 0) ? TT - act / DV : 0;
         chk("rtmr_val", tempo_restante, t);
         chk("rtmr_to", timeout, t == 0);
         chk("rtmr_bcd", tempo_bcd, exp_bcd(pt));
         pt = t;
      end
      contaT = 0;

      // hit counter
      zeraA = 1; tick(); zeraA = 0;
      chk("ac_clr", acertos, 0);
      contaA = 1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("ac_sat", acertos, (k < MA) ? k : MA);
      end
      zeraA = 1; tick();
      chk("ac_prio", acertos, 0);
      zeraA = 0; contaA = 0;
      h = 0;
      for (int k = 0; k < 20; k++) begin
         zs = ($urandom_range(0, 4) == 0);
         cs = 1'($urandom_range(0, 1));
         zeraA = zs; contaA = cs;
         tick();
         if (zs) h = 0;
         else if (cs && h < MA) h++;
         chk("rac", acertos, h);
      end
      zeraA = 1; contaA = 0; tick(); zeraA = 0;

      // blink sequence
      chk("pk_idle", leds, leds_mem);
      contaPiscadas = 1; tick(); contaPiscadas = 0;
      for (int k = 0; k < 16; k++) begin
         leds_mem = 4'($urandom_range(0, 15)); #1;
         if (k / LC < 2 * PS) begin
            chk("pk_leds", leds, ((k / LC) % 2 == 0) ? leds_mem : 4'd0);
            chk("pk_fim", fimPiscaLeds, 0);
         end else begin
            chk("pk_dleds", leds, 0);
            chk("pk_done", fimPiscaLeds, 1);
         end
         tick();
      end
      zeraA = 1; tick(); zeraA = 0;
      chk("pk_back", leds, leds_mem);
      chk("pk_back_fim", fimPiscaLeds, 0);

      // reset while blinking and while the timer runs
      leds_mem = 4'b0110;
      contaT = 1;
      contaPiscadas = 1; tick(); contaPiscadas = 0;
      chk("pr_on", leds, 4'b0110);
      tick();
      reset = 0; #1;
      chk("pr_leds", leds, 4'b0110);
      chk("pr_fim", fimPiscaLeds, 0);
      chk("pr_tempo", tempo_restante, TT);
      chk("pr_end", endereco, 0);
      chk("pr_modo", modo, 0);
      contaT = 0;
      tick();
      reset = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("pr_idle", leds, 4'b0110);
         chk("pr_tem", tem_jogada, 0);
         chk("pr_hold", tempo_restante, TT);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
